tristate_bus_arbiter: RTL and testbench

Round-robin arbiter and turnaround sequencer for a shared tri-state net kept by a bus-hold cell. It grants exactly one requester at a time. It inserts TA idle cycles between owners so two drivers never overlap, and the keeper holds the last value during idle cycles. A watchdog revokes a grant after MAXHOLD cycles, so no single requester can starve the others. It sits next to the keeper cell, and its grant vector drives the requesters' output-enable pins directly.

---
 rtl/tristate_bus_arbiter_if.sv | 15 +
 rtl/tristate_bus_arbiter.sv | 113 +++++++++++
 tb/tb_tristate_bus_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/tristate_bus_arbiter_if.sv
// rtl/tristate_bus_arbiter_if.sv - request/grant bundle between requesters and the tri-state bus arbiter
interface tristate_bus_arbiter_if #(
  parameter int N = 4
);
  localparam int OW = $clog2(N);

  logic [N-1:0]  REQ;
  logic [N-1:0]  GNT;
  logic [OW-1:0] OWNER;
  logic          HOLDING;
  logic          TIMEOUT;

  modport master (output REQ, input GNT, input OWNER, input HOLDING, input TIMEOUT);
  modport slave  (input REQ, output GNT, output OWNER, output HOLDING, output TIMEOUT);
endinterface

// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - round-robin grant sequencer with turnaround gaps and hold watchdog for a kept tri-state net
module tristate_bus_arbiter #(
  parameter int N       = 4,
  parameter int TA      = 1,
  parameter int MAXHOLD = 16
) (
  input  logic                 CLK,
  input  logic                 RN,
  inout  wire                  VDD,
  inout  wire                  VSS,
  tristate_bus_arbiter_if.slave bus
);
  localparam int OW = $clog2(N);
  localparam int HW = (MAXHOLD == 0) ? 1 : $clog2(MAXHOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

  state_t        r_state, w_state_nx;
  logic [N-1:0]  r_gnt, w_gnt_nx;
  logic [OW-1:0] r_owner, w_owner_nx;
  logic [OW-1:0] r_ptr, w_ptr_nx;
  logic [HW-1:0] r_hold, w_hold_nx;
  logic [2:0]    r_turn, w_turn_nx;
  logic          r_timeout, w_timeout_nx;
  logic [OW-1:0] w_idx;
  logic [OW-1:0] w_win;
  logic          w_found;

  wire w_unused_pwr = VDD ^ VSS;

  // Rotating search: the slot after the last owner is examined first.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = OW'((int'(r_ptr) + i) % N);
      if (!w_found && bus.REQ[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_gnt_nx     = r_gnt;
    w_owner_nx   = r_owner;
    w_ptr_nx     = r_ptr;
    w_hold_nx    = r_hold;
    w_turn_nx    = r_turn;
    w_timeout_nx = 1'b0;
    case (r_state)
      S_GRANT: begin
        // A release on the expiry edge wins over the watchdog.
        if (!bus.REQ[r_owner]) begin
          w_state_nx = S_TURN;
          w_gnt_nx   = '0;
          w_turn_nx  = 3'd1;
        end else if (MAXHOLD != 0 && r_hold == HW'(MAXHOLD)) begin
          w_state_nx   = S_TURN;
          w_gnt_nx     = '0;
          w_turn_nx    = 3'd1;
          w_timeout_nx = 1'b1;
        end else if (r_hold != '1) begin
          w_hold_nx = r_hold + 1'b1;
        end
      end
      S_IDLE, S_TURN: begin
        if (r_state == S_TURN && r_turn < 3'(TA)) begin
          w_turn_nx = r_turn + 3'd1;
        end else if (w_found) begin
          w_state_nx = S_GRANT;
          w_gnt_nx   = N'(1) << w_win;
          w_owner_nx = w_win;
          w_ptr_nx   = w_win;
          w_hold_nx  = HW'(1);
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_ptr     <= OW'(N - 1);
      r_hold    <= '0;
      r_turn    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_gnt     <= w_gnt_nx;
      r_owner   <= w_owner_nx;
      r_ptr     <= w_ptr_nx;
      r_hold    <= w_hold_nx;
      r_turn    <= w_turn_nx;
      r_timeout <= w_timeout_nx;
    end
  end

  assign bus.GNT     = r_gnt;
  assign bus.OWNER   = r_owner;
  assign bus.HOLDING = ~|r_gnt;
  assign bus.TIMEOUT = r_timeout;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - scoreboard bench for three arbiter configurations driven side by side
module tb_tristate_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rn;
  wire  vdd;
  wire  vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  tristate_bus_arbiter_if #(.N(4)) bus_a ();
  tristate_bus_arbiter_if #(.N(4)) bus_w ();
  tristate_bus_arbiter_if #(.N(4)) bus_e ();

  tristate_bus_arbiter #(.N(4), .TA(1), .MAXHOLD(16)) dut_a (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .bus(bus_a));
  tristate_bus_arbiter #(.N(4), .TA(1), .MAXHOLD(8)) dut_w (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .bus(bus_w));
  tristate_bus_arbiter #(.N(4), .TA(3), .MAXHOLD(4)) dut_e (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .bus(bus_e));

  typedef struct {
    logic [3:0] gnt;
    logic       to;
    logic       hold;
    logic [1:0] own;
    bit         chk_own;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int p_ta[3] = '{1, 1, 3};
  int p_mh[3] = '{16, 8, 4};
  int m_own[3];
  int m_last[3];
  int m_held[3];
  int m_gap[3];
  int m_eown[3];
  bit m_turn[3];
  logic [3:0] req_v[3];

  logic [3:0] act_gnt[3];
  logic [1:0] act_own[3];
  logic       act_to[3];
  logic       act_hold[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] r, input logic rst_n);
    exp_t e;
    int   pick;
    e.to      = 1'b0;
    e.chk_own = 1'b0;
    if (!rst_n) begin
      m_own[k] = -1; m_last[k] = 3; m_held[k] = 0; m_gap[k] = 0; m_turn[k] = 0; m_eown[k] = 0;
      e.chk_own = 1'b1;
    end else if (m_own[k] >= 0) begin
      if (!r[m_own[k]]) begin
        m_own[k] = -1; m_turn[k] = 1; m_gap[k] = 1;
      end else if (p_mh[k] != 0 && m_held[k] == p_mh[k]) begin
        m_own[k] = -1; m_turn[k] = 1; m_gap[k] = 1; e.to = 1'b1;
      end else begin
        m_held[k]++;
      end
    end else if (m_turn[k] && m_gap[k] < p_ta[k]) begin
      m_gap[k]++;
    end else begin
      pick = -1;
      for (int i = 1; i <= 4; i++)
        if (pick < 0 && r[(m_last[k] + i) % 4]) pick = (m_last[k] + i) % 4;
      m_turn[k] = 0;
      if (pick >= 0) begin
        m_own[k] = pick; m_last[k] = pick; m_held[k] = 1; m_eown[k] = pick;
      end
    end
    e.gnt  = (m_own[k] >= 0) ? 4'(1 << m_own[k]) : 4'b0000;
    e.hold = (m_own[k] < 0);
    e.own  = 2'(m_eown[k]);
    if (m_own[k] >= 0) e.chk_own = 1'b1;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    bus_a.REQ = req_v[0];
    bus_w.REQ = req_v[1];
    bus_e.REQ = req_v[2];
    for (int k = 0; k < 3; k++) model_step(k, req_v[k], rn);
    @(posedge clk);
    #1;
    act_gnt[0] = bus_a.GNT; act_own[0] = bus_a.OWNER; act_to[0] = bus_a.TIMEOUT; act_hold[0] = bus_a.HOLDING;
    act_gnt[1] = bus_w.GNT; act_own[1] = bus_w.OWNER; act_to[1] = bus_w.TIMEOUT; act_hold[1] = bus_w.HOLDING;
    act_gnt[2] = bus_e.GNT; act_own[2] = bus_e.OWNER; act_to[2] = bus_e.TIMEOUT; act_hold[2] = bus_e.HOLDING;
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      check($sformatf("gnt%0d", k), 32'(act_gnt[k]), 32'(e.gnt));
      check($sformatf("timeout%0d", k), 32'(act_to[k]), 32'(e.to));
      check($sformatf("holding%0d", k), 32'(act_hold[k]), 32'(e.hold));
      check($sformatf("onehot%0d", k), 32'($onehot0(act_gnt[k])), 32'd1);
      if (e.chk_own) check($sformatf("owner%0d", k), 32'(act_own[k]), 32'(e.own));
    end
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  int         rr_seen[$];
  int         rr_exp[5] = '{0, 1, 2, 3, 0};
  logic [3:0] prev_a;
  int         cnt_g0, cnt_g1, cnt_to;

  initial begin
    rn = 1'b0;
    for (int k = 0; k < 3; k++) req_v[k] = 4'b1111;
    run(2);
    rn = 1'b1;
    run(1);
    for (int k = 0; k < 3; k++) req_v[k] = 4'b0000;
    run(6);

    req_v[0] = 4'b0100;
    run(5);
    req_v[0] = 4'b0000;
    run(4);

    rn = 1'b0;
    run(1);
    rn = 1'b1;
    prev_a = 4'b0000;
    for (int c = 0; c < 18; c++) begin
      req_v[0] = 4'b1111;
      if (m_own[0] >= 0 && m_held[0] == 3) req_v[0][m_own[0]] = 1'b0;
      step();
      if (act_gnt[0] != 4'b0000 && prev_a == 4'b0000) rr_seen.push_back(int'(act_own[0]));
      prev_a = act_gnt[0];
    end
    req_v[0] = 4'b0000;
    run(4);
    check("rr_count", 32'(rr_seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < rr_seen.size(); i++)
      check($sformatf("rr_order%0d", i), 32'(rr_seen[i]), 32'(rr_exp[i]));

    cnt_g0 = 0; cnt_g1 = 0; cnt_to = 0;
    req_v[1] = 4'b0011;
    for (int c = 0; c < 21; c++) begin
      if (c == 18) req_v[1] = 4'b0000;
      step();
      if (act_gnt[1] == 4'b0001) cnt_g0++;
      if (act_gnt[1] == 4'b0010) cnt_g1++;
      if (act_to[1]) cnt_to++;
    end
    check("wd_gnt0_cycles", 32'(cnt_g0), 32'd8);
    check("wd_gnt1_cycles", 32'(cnt_g1), 32'd8);
    check("wd_timeouts", 32'(cnt_to), 32'd2);

    cnt_g0 = 0; cnt_to = 0;
    req_v[2] = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) req_v[2] = 4'b0000;
      step();
      if (act_gnt[2] == 4'b0001) cnt_g0++;
      if (act_to[2]) cnt_to++;
    end
    check("edge_gnt_cycles", 32'(cnt_g0), 32'd4);
    check("edge_timeouts", 32'(cnt_to), 32'd0);
    req_v[2] = 4'b0011;
    run(14);
    req_v[2] = 4'b0000;
    run(6);

    req_v[0] = 4'b0010;
    run(3);
    rn = 1'b0;
    req_v[0] = 4'b0011;
    run(1);
    rn = 1'b1;
    run(2);
    check("reset_owner0", 32'(act_own[0]), 32'd0);
    req_v[0] = 4'b0000;
    run(4);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
